// File: rtl/divisor_4bit_pkg.sv
// Shared types and constants for the 4-bit restoring divider.
package divisor_4bit_pkg;

  localparam int unsigned W     = 4;
  localparam int unsigned ITER  = 4;
  localparam int unsigned CNT_W = 2;

  localparam logic SUB = 1'b1;
  localparam logic ADD = 1'b0;

  // Quotient reported for a zero divisor
  localparam logic [W-1:0] DZ_QUOT = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/restador_4bit.sv
// 4-bit add/sub unit: S = A + B (select=0) or A - B (select=1); Cout=1 means no borrow on subtract.
module restador_4bit
  import divisor_4bit_pkg::*;
(
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         select,
  output logic [W-1:0] S,
  output logic         Cout
);

  logic [W-1:0] w_b_eff;
  logic [W:0]   w_sum;

  // Two's-complement subtract: invert B and inject select as carry-in
  assign w_b_eff = B ^ {W{select}};
  assign w_sum   = {1'b0, A} + {1'b0, w_b_eff} + {{W{1'b0}}, select};
  assign S       = w_sum[W-1:0];
  assign Cout    = w_sum[W];

endmodule

// File: rtl/divisor_4bit.sv
// Sequential restoring divider: one quotient bit per RUN cycle, registered results and handshake.
module divisor_4bit
  import divisor_4bit_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic [W-1:0] Q,
  output logic [W-1:0] R,
  output logic         busy,
  output logic         done,
  output logic         div_zero
);

  state_t r_state;
  state_t w_state_nxt;

  logic [W-1:0]     r_p,     w_p_nxt;
  logic [W-1:0]     r_dvd,   w_dvd_nxt;
  logic [W-1:0]     r_dvs,   w_dvs_nxt;
  logic [W-1:0]     r_quot,  w_quot_nxt;
  logic [CNT_W-1:0] r_count, w_count_nxt;
  logic [W-1:0]     w_q_nxt, w_r_nxt;
  logic             w_busy_nxt, w_done_nxt, w_dz_nxt;

  logic [W-1:0] w_shift_p;
  logic         w_e;
  logic [W-1:0] w_diff;
  logic         w_cout;
  logic         w_take;
  logic [W-1:0] w_p_step;
  logic [W-1:0] w_q_step;

  // Shift {P,dividend} left; the bit leaving P[3] acts as a 5th partial-remainder bit
  assign w_shift_p = {r_p[W-2:0], r_dvd[W-1]};
  assign w_e       = r_p[W-1];

  restador_4bit u_sub (
    .A      (w_shift_p),
    .B      (r_dvs),
    .select (SUB),
    .S      (w_diff),
    .Cout   (w_cout)
  );

  assign w_take   = w_e | w_cout;
  assign w_p_step = w_take ? w_diff : w_shift_p;
  assign w_q_step = {r_quot[W-2:0], w_take};

  // Next-state and next-register values
  always_comb begin
    w_state_nxt = r_state;
    w_p_nxt     = r_p;
    w_dvd_nxt   = r_dvd;
    w_dvs_nxt   = r_dvs;
    w_quot_nxt  = r_quot;
    w_count_nxt = r_count;
    w_q_nxt     = Q;
    w_r_nxt     = R;
    w_dz_nxt    = div_zero;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_dvd_nxt   = A;
          w_dvs_nxt   = B;
          w_p_nxt     = '0;
          w_quot_nxt  = '0;
          w_count_nxt = '0;
          w_dz_nxt    = 1'b0;
          if (B == W'(0)) begin
            w_state_nxt = DONE;
            w_q_nxt     = DZ_QUOT;
            w_r_nxt     = A;
            w_dz_nxt    = 1'b1;
          end else begin
            w_state_nxt = RUN;
          end
        end
      end
      RUN: begin
        w_p_nxt     = w_p_step;
        w_quot_nxt  = w_q_step;
        w_dvd_nxt   = {r_dvd[W-2:0], 1'b0};
        w_count_nxt = r_count + CNT_W'(1);
        if (r_count == CNT_W'(ITER - 1)) begin
          w_state_nxt = DONE;
          w_q_nxt     = w_q_step;
          w_r_nxt     = w_p_step;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != IDLE);
    w_done_nxt = (w_state_nxt == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_p      <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_quot   <= '0;
      r_count  <= '0;
      Q        <= '0;
      R        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_p      <= w_p_nxt;
      r_dvd    <= w_dvd_nxt;
      r_dvs    <= w_dvs_nxt;
      r_quot   <= w_quot_nxt;
      r_count  <= w_count_nxt;
      Q        <= w_q_nxt;
      R        <= w_r_nxt;
      busy     <= w_busy_nxt;
      done     <= w_done_nxt;
      div_zero <= w_dz_nxt;
    end
  end

endmodule

// File: tb/tb_divisor_4bit.sv
// Directed and exhaustive self-checking bench for divisor_4bit.
module tb_divisor_4bit;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] A, B, Q, R;
  logic       busy, done, div_zero;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  divisor_4bit dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .A        (A),
    .B        (B),
    .Q        (Q),
    .R        (R),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Drive one division and observe it; lat=0 means done never arrived
  task automatic do_div(input logic [3:0] a, input logic [3:0] b,
                        output logic [3:0] q, output logic [3:0] r,
                        output logic dz, output int lat, output logic busy_ok);
    q = 4'd0; r = 4'd0; dz = 1'b0; lat = 0; busy_ok = 1'b1;
    @(negedge clk);
    start = 1'b1; A = a; B = b;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) begin
        lat = i; q = Q; r = R; dz = div_zero;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int lat;
    rst = 1'b1; start = 1'b0; A = 4'd0; B = 4'd0;
    repeat (2) @(negedge clk);
    total++;
    if ({Q, R, busy, done, div_zero} !== 11'd0) begin
      bad++;
      $display("FAIL reset_state: got Q=%0d R=%0d busy=%b done=%b dz=%b required all 0",
               Q, R, busy, done, div_zero);
    end
    // Reset wins over start on the same edge
    start = 1'b1; A = 4'd5; B = 4'd1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_priority: busy got %b required 0", busy);
    end
    // First cycle with rst low accepts the start
    rst = 1'b0; A = 4'd6; B = 4'd3;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL first_accept: busy got %b required 1", busy);
    end
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      if (done === 1'b1) begin lat = i; break; end
      @(negedge clk);
    end
    total++;
    if (lat != 5 || Q !== 4'd2 || R !== 4'd0) begin
      bad++;
      $display("FAIL first_accept_result: got lat=%0d Q=%0d R=%0d required lat=5 Q=2 R=0",
               lat, Q, R);
    end
  endtask

  task automatic test_basic();
    logic [3:0] q, r; logic dz, bok; int lat;
    do_div(4'd13, 4'd3, q, r, dz, lat, bok);
    total++;
    if (lat != 5) begin
      bad++; $display("FAIL basic_latency: got %0d required 5", lat);
    end
    total++;
    if (q !== 4'd4 || r !== 4'd1 || dz !== 1'b0) begin
      bad++; $display("FAIL basic_result: got Q=%0d R=%0d dz=%b required Q=4 R=1 dz=0", q, r, dz);
    end
    total++;
    if (bok !== 1'b1) begin
      bad++; $display("FAIL basic_busy: busy dropped before done, got %b required 1", bok);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || Q !== 4'd4 || R !== 4'd1) begin
      bad++;
      $display("FAIL basic_after_done: got done=%b busy=%b Q=%0d R=%0d required 0 0 4 1",
               done, busy, Q, R);
    end
  endtask

  task automatic test_vectors();
    logic [3:0] va [5]; logic [3:0] vb [5]; logic [3:0] vq [5]; logic [3:0] vr [5];
    logic vdz [5]; int vlat [5];
    logic [3:0] q, r; logic dz, bok; int lat;
    va = '{4'd15, 4'd15, 4'd7, 4'd9,  4'd13};
    vb = '{4'd2,  4'd1,  4'd9, 4'd0,  4'd3};
    vq = '{4'd7,  4'd15, 4'd0, 4'd15, 4'd4};
    vr = '{4'd1,  4'd0,  4'd7, 4'd9,  4'd1};
    vdz = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vlat = '{5, 5, 5, 1, 5};
    for (int k = 0; k < 5; k++) begin
      do_div(va[k], vb[k], q, r, dz, lat, bok);
      total++;
      if (q !== vq[k] || r !== vr[k] || dz !== vdz[k] || lat != vlat[k]) begin
        bad++;
        $display("FAIL vector_%0d_%0d: got Q=%0d R=%0d dz=%b lat=%0d required Q=%0d R=%0d dz=%b lat=%0d",
                 va[k], vb[k], q, r, dz, lat, vq[k], vr[k], vdz[k], vlat[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] q, r; logic dz, bok; int lat;
    @(negedge clk);
    start = 1'b1; A = 4'd13; B = 4'd3;
    @(negedge clk);
    A = 4'd6; B = 4'd2;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      if (done === 1'b1) begin lat = i; break; end
      @(negedge clk);
    end
    total++;
    if (lat != 5 || Q !== 4'd4 || R !== 4'd1) begin
      bad++;
      $display("FAIL start_while_busy: got lat=%0d Q=%0d R=%0d required lat=5 Q=4 R=1", lat, Q, R);
    end
    // start still high through the DONE cycle must be ignored
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL start_in_done: busy got %b required 0", busy);
    end
    do_div(4'd6, 4'd2, q, r, dz, lat, bok);
    total++;
    if (q !== 4'd3 || r !== 4'd0 || lat != 5) begin
      bad++; $display("FAIL next_start: got Q=%0d R=%0d lat=%0d required Q=3 R=0 lat=5", q, r, lat);
    end
  endtask

  task automatic test_abort();
    logic [3:0] q, r; logic dz, bok; int lat; logic saw_done;
    @(negedge clk);
    start = 1'b1; A = 4'd13; B = 4'd3;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || Q !== 4'd3 || R !== 4'd0) begin
      bad++;
      $display("FAIL hold_during_run: got busy=%b Q=%0d R=%0d required 1 3 0", busy, Q, R);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (busy !== 1'b0 || Q !== 4'd0 || R !== 4'd0 || done !== 1'b0) begin
      bad++;
      $display("FAIL abort_state: got busy=%b Q=%0d R=%0d done=%b required 0 0 0 0",
               busy, Q, R, done);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    total++;
    if (saw_done !== 1'b0) begin
      bad++; $display("FAIL abort_no_done: got done pulse=%b required 0", saw_done);
    end
    do_div(4'd8, 4'd3, q, r, dz, lat, bok);
    total++;
    if (q !== 4'd2 || r !== 4'd2 || lat != 5) begin
      bad++; $display("FAIL after_abort: got Q=%0d R=%0d lat=%0d required Q=2 R=2 lat=5", q, r, lat);
    end
  endtask

  task automatic test_exhaustive();
    logic [3:0] q, r, eq, er; logic dz, edz, bok; int lat, elat; int ndone;
    ndone = 0;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        do_div(4'(a), 4'(b), q, r, dz, lat, bok);
        if (lat != 0) ndone++;
        if (b == 0) begin
          eq = 4'hF; er = 4'(a); edz = 1'b1; elat = 1;
        end else begin
          eq = 4'(a / b); er = 4'(a % b); edz = 1'b0; elat = 5;
        end
        total++;
        if (q !== eq || r !== er || dz !== edz || lat != elat) begin
          bad++;
          $display("FAIL exh_%0d_%0d: got Q=%0d R=%0d dz=%b lat=%0d required Q=%0d R=%0d dz=%b lat=%0d",
                   a, b, q, r, dz, lat, eq, er, edz, elat);
        end
      end
    end
    total++;
    if (ndone != 256) begin
      bad++; $display("FAIL exh_done_count: got %0d required 256", ndone);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; A = 4'd0; B = 4'd0;
    test_reset();
    test_basic();
    test_vectors();
    test_back_to_back();
    test_abort();
    test_exhaustive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
